// File: rtl/reel_spin_ctrl.sv
// Slot-machine reel controller: free-running symbol counters, one reel frozen per debounced press.
// Press acts two edges after stop_n is first sampled low; result_valid pulses once on DONE entry.
module reel_spin_ctrl #(
   parameter int NUM_REELS = 3,
   parameter int SYM_W     = 4,
   parameter int LOCKOUT   = 500000
) (
   input  logic                         CLOCK_50,
   input  logic                         reset,
   input  logic                         stop_n,
   output logic [NUM_REELS*SYM_W-1:0]   reels,
   output logic [NUM_REELS-1:0]         stopped,
   output logic                         busy,
   output logic                         done,
   output logic                         result_valid,
   output logic                         all_match,
   output logic                         pair_match
);

   localparam int NR_W = (NUM_REELS > 2) ? $clog2(NUM_REELS) : 1;
   localparam int LK_W = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
   localparam logic [NR_W-1:0] LAST = NR_W'(NUM_REELS - 1);

   typedef enum logic [1:0] {IDLE, SPIN, DONE} state_t;

   state_t            state;
   logic [NR_W-1:0]   next_reel;
   logic              s0, s1, s_prev;
   logic [LK_W-1:0]   lock_cnt;
   logic              press;
   logic [SYM_W-1:0]  cnt [NUM_REELS];
   logic [SYM_W-1:0]  lat [NUM_REELS];
   logic [SYM_W-1:0]  fin [NUM_REELS];
   logic              fin_all, fin_pair;

   assign press = s_prev & ~s1 & (lock_cnt == '0);

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         s0       <= 1'b1;
         s1       <= 1'b1;
         s_prev   <= 1'b1;
         lock_cnt <= '0;
      end else begin
         s0     <= stop_n;
         s1     <= s0;
         s_prev <= s1;
         if (press)
            lock_cnt <= LK_W'(LOCKOUT - 1);
         else if (lock_cnt != '0)
            lock_cnt <= lock_cnt - LK_W'(1);
      end
   end

   // Odd step per reel guarantees every reel cycles through all 2^SYM_W symbols.
   always_ff @(posedge CLOCK_50) begin
      for (int r = 0; r < NUM_REELS; r++) begin
         if (reset)
            cnt[r] <= '0;
         else
            cnt[r] <= cnt[r] + SYM_W'(2*r + 1);
      end
   end

   // Latched set as it will look after the current press, so match flags land with DONE.
   always_comb begin
      for (int r = 0; r < NUM_REELS; r++)
         fin[r] = lat[r];
      fin[next_reel] = cnt[next_reel];
      fin_all  = 1'b1;
      fin_pair = 1'b0;
      for (int i = 1; i < NUM_REELS; i++)
         if (fin[i] != fin[0])
            fin_all = 1'b0;
      for (int i = 0; i < NUM_REELS; i++)
         for (int j = i + 1; j < NUM_REELS; j++)
            if (fin[i] == fin[j])
               fin_pair = 1'b1;
   end

   always_comb begin
      reels = '0;
      for (int r = 0; r < NUM_REELS; r++)
         if (state != IDLE)
            reels[r*SYM_W +: SYM_W] = stopped[r] ? lat[r] : cnt[r];
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state        <= IDLE;
         next_reel    <= LAST;
         stopped      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         result_valid <= 1'b0;
         all_match    <= 1'b0;
         pair_match   <= 1'b0;
         for (int r = 0; r < NUM_REELS; r++)
            lat[r] <= '0;
      end else begin
         result_valid <= 1'b0;
         case (state)
            IDLE: if (press) begin
               state     <= SPIN;
               busy      <= 1'b1;
               next_reel <= LAST;
            end
            SPIN: if (press) begin
               lat[next_reel]     <= cnt[next_reel];
               stopped[next_reel] <= 1'b1;
               if (next_reel == '0) begin
                  state        <= DONE;
                  busy         <= 1'b0;
                  done         <= 1'b1;
                  result_valid <= 1'b1;
                  all_match    <= fin_all;
                  pair_match   <= fin_pair;
               end else begin
                  next_reel <= next_reel - NR_W'(1);
               end
            end
            DONE: if (press) begin
               state      <= IDLE;
               done       <= 1'b0;
               stopped    <= '0;
               all_match  <= 1'b0;
               pair_match <= 1'b0;
               for (int r = 0; r < NUM_REELS; r++)
                  lat[r] <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reel_spin_ctrl.sv
// Directed bench for reel_spin_ctrl (3 reels, 4-bit symbols, lockout 4); results checked via scoreboard.
module tb_reel_spin_ctrl;

   logic        CLOCK_50 = 1'b0;
   logic        reset = 1'b1;
   logic        stop_n = 1'b1;
   logic [11:0] reels;
   logic [2:0]  stopped;
   logic        busy, done, result_valid, all_match, pair_match;

   int ncnt = 0;
   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [11:0] reels;
      logic [2:0]  stopped;
      logic        all;
      logic        pair;
   } exp_t;
   exp_t sb[$];

   reel_spin_ctrl #(.NUM_REELS(3), .SYM_W(4), .LOCKOUT(4)) dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .stop_n      (stop_n),
      .reels       (reels),
      .stopped     (stopped),
      .busy        (busy),
      .done        (done),
      .result_valid(result_valid),
      .all_match   (all_match),
      .pair_match  (pair_match)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   // Edges since reset released: the value the reel counters should reflect.
   always @(posedge CLOCK_50) ncnt <= reset ? 0 : ncnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (n=%0d)", name, act, exp, ncnt);
      end
   endtask

   function automatic logic [11:0] live(input int n);
      logic [3:0] r2, r1, r0;
      r2 = 4'(n * 5);
      r1 = 4'(n * 3);
      r0 = 4'(n);
      return {r2, r1, r0};
   endfunction

   task automatic to_n(input int n);
      int g = 0;
      do begin
         @(negedge CLOCK_50);
         g++;
      end while (ncnt != n && g < 2000);
      if (ncnt != n) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_n: got %0d expected %0d", ncnt, n);
      end
   endtask

   // Press pulse lands in the cycle whose counters read n; returns at negedge of cycle n-2+hold.
   task automatic press_at(input int n, input int hold);
      to_n(n - 2);
      stop_n = 1'b0;
      repeat (hold) @(negedge CLOCK_50);
      stop_n = 1'b1;
   endtask

   always @(negedge CLOCK_50) begin
      if (result_valid) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_result: got result_valid=1 expected no result (n=%0d)", ncnt);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("res_reels",   32'(reels),      32'(e.reels));
            chk("res_stopped", 32'(stopped),    32'(e.stopped));
            chk("res_all",     32'(all_match),  32'(e.all));
            chk("res_pair",    32'(pair_match), 32'(e.pair));
            chk("res_done",    32'(done),       32'd1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      exp_t e;
      logic [11:0] lv;

      repeat (3) @(negedge CLOCK_50);
      chk("rst_reels",   32'(reels),   32'h0);
      chk("rst_stopped", 32'(stopped), 32'h0);
      chk("rst_flags",   32'({busy, done, result_valid, all_match, pair_match}), 32'h0);
      reset = 1'b0;

      // Spin 1: stops at 10, 20, 30 -> 0x2CE, no matches.
      press_at(3, 3);
      chk("spin_busy",    32'(busy),    32'd1);
      chk("spin_stopped", 32'(stopped), 32'h0);
      chk("spin_live",    32'(reels),   32'h4C4);
      e.reels = 12'h2CE; e.stopped = 3'b111; e.all = 1'b0; e.pair = 1'b0;
      sb.push_back(e);
      press_at(10, 3);
      lv = live(11);
      chk("stop2_stopped", 32'(stopped), 32'b100);
      chk("stop2_reels",   32'(reels),   32'({4'h2, lv[7:0]}));
      press_at(20, 3);
      lv = live(21);
      chk("stop1_stopped", 32'(stopped), 32'b110);
      chk("stop1_reels",   32'(reels),   32'({8'h2C, lv[3:0]}));
      press_at(30, 3);
      chk("done_state", 32'({busy, done}), 32'b01);
      chk("done_reels", 32'(reels),        32'h2CE);
      @(negedge CLOCK_50);
      chk("rv_one_cycle", 32'(result_valid), 32'd0);
      chk("done_hold",    32'(done),         32'd1);

      // DONE -> IDLE, then IDLE -> SPIN with live reels.
      press_at(40, 3);
      chk("idle_reels",   32'(reels),   32'h0);
      chk("idle_stopped", 32'(stopped), 32'h0);
      chk("idle_flags",   32'({busy, done, all_match, pair_match}), 32'h0);
      press_at(45, 3);
      chk("respin_busy", 32'(busy),  32'd1);
      chk("respin_live", 32'(reels), 32'(live(46)));
      press_at(55, 3);
      chk("abort_pre_stopped", 32'(stopped), 32'b100);

      // Reset mid-spin: everything clears, no result.
      @(negedge CLOCK_50);
      reset = 1'b1;
      @(negedge CLOCK_50);
      chk("abort_reels",   32'(reels),   32'h0);
      chk("abort_stopped", 32'(stopped), 32'h0);
      chk("abort_flags",   32'({busy, done, result_valid, all_match, pair_match}), 32'h0);
      reset = 1'b0;

      // Spin 2: stops at 16, 32, 48 -> all reels zero, full match.
      press_at(3, 3);
      e.reels = 12'h000; e.stopped = 3'b111; e.all = 1'b1; e.pair = 1'b1;
      sb.push_back(e);
      press_at(16, 3);
      press_at(32, 3);
      press_at(48, 3);
      chk("match_done", 32'({done, all_match, pair_match}), 32'b111);

      // Bounce: accepted press at 60 (DONE -> IDLE); re-fall at 63 lies inside lockout.
      to_n(58); stop_n = 1'b0;
      to_n(60); stop_n = 1'b1;
      to_n(61); stop_n = 1'b0;
      to_n(62); stop_n = 1'b1;
      chk("bounce_idle", 32'({busy, done}), 32'b00);
      to_n(68);
      chk("bounce_once", 32'({busy, done}), 32'b00);
      press_at(72, 3);
      chk("after_lock_press", 32'(busy), 32'd1);

      // Long hold in SPIN stops exactly one reel.
      press_at(80, 100);
      chk("hold_stopped", 32'(stopped),     32'b100);
      chk("hold_reel2",   32'(reels[11:8]), 32'h0);
      chk("hold_busy",    32'(busy),        32'd1);

      repeat (5) @(negedge CLOCK_50);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
